axi4_slot_arbiter: RTL
======================

Name: axi4_slot_arbiter

Overview:
- Shares one AXI4 master port between slot_num_p AXI4 slave slots.
- Round-robin arbitration runs independently on the write path (AW/W/B) and the read path (AR/R).
- Each path allows one transaction in flight: one burst per direction, matching the single-issue configuration of the existing slot-mux fabric.
- Sits between the per-slot host/DMA initiators and the shared memory-side AXI4 port; it sequences the shared port and routes responses back to the owning slot.

Parameters:
- slot_num_p, "inv", number of slave slots (2..16).
- id_width_p, "inv", AXI ID width, passed through unchanged.
- addr_width_p, "inv", AXI address width.
- data_width_p, "inv", AXI data width; wstrb width is data_width_p/8.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous, active-high reset.
- s_axi4_par_i  in  [slot_num_p][axi4_mosi_bus_width]  per-slot AXI4 master-to-slave bundles.
- s_axi4_par_o  out  [slot_num_p][axi4_miso_bus_width]  per-slot AXI4 slave-to-master bundles.
- m_axi4_ser_o  out  axi4_mosi_bus_width (1 slot)  shared master bundle.
- m_axi4_ser_i  in  axi4_miso_bus_width (1 slot)  shared master response bundle.
- wr_busy_o  out  1  write path not idle.
- rd_busy_o  out  1  read path not idle.
- wr_grant_o  out  log2(slot_num_p)  current or last write grant.
- rd_grant_o  out  log2(slot_num_p)  current or last read grant.

Behaviour:

Reset (asynchronous, takes effect immediately):
- Both FSMs go to IDLE; grant registers and round-robin pointers go to 0.
- All valid and ready outputs go to 0, on both the m side and every slot; busy flags go to 0.
- A reset during a burst abandons it. No completion is generated.

Write FSM, states W_IDLE, W_ADDR, W_DATA, W_RESP:
- W_IDLE: if any awvalid is high, the round-robin picks a slot, searching from ptr_w upward and wrapping modulo slot_num_p. Register the grant and go to W_ADDR next cycle.
- Latency: awvalid sampled at cycle t gives m awvalid at t+1.
- W_ADDR: m AW fields are a mux of the granted slot; m awvalid equals that slot's awvalid; the granted slot's awready equals m awready. On the AW handshake go to W_DATA.
- W_DATA: W fields, wvalid and wready are connected between the granted slot and m. On a W handshake with wlast set, go to W_RESP.
- W_RESP: bid, bresp and bvalid route to the granted slot only; m bready equals the granted slot's bready. On the B handshake: ptr_w becomes grant+1 (wrapping from slot_num_p-1 to 0), and the FSM goes to W_IDLE.
- W before AW: W data is accepted only in W_DATA. A slot that presents wvalid early sees wready=0 until its AW completes (legal AXI slave behaviour).

Read FSM, states R_IDLE, R_ADDR, R_DATA:
- Same arbitration and AR muxing as the write path.
- R_DATA: rid, rdata, rresp, rlast and rvalid route to the granted slot; m rready equals that slot's rready.
- The R handshake with rlast set advances ptr_r to grant+1 and returns to R_IDLE.

Common rules:
- Non-granted slots always see awready, wready, bvalid, arready and rvalid at 0; their output data fields are 0.
- m-side valids are 0 in every state other than those listed above.
- Arbitration happens only in IDLE. A request arriving mid-burst waits; it is not dropped.
- Fairness: with all slots continuously requesting, grants rotate 0,1,...,N-1,0.
- Read and write run concurrently. The same slot may hold both grants.
- awregion/arregion, awqos/arqos, awlock/arlock, awcache/arcache and awprot/arprot pass through unchanged from the granted slot.
- Simulation assertion: slot_num_p in 2..16.

Decomposition:
- Shared package bsg_axi_bus_pkg: add the write-state and read-state enums, and a grant-width macro `BSG_SAFE_CLOG2(slot_num_p)`. Reuse the existing bus-struct declare macros for casts.
- Sub-module axi4_slot_rr_arb: parameter slot_num_p. Inputs reqs_i and yumi_i; outputs grant_o (one-hot and encoded) and v_o; holds the pointer internally. Instantiate it twice, once for the write path and once for the read path.

Test Plan:
- 4 slots, reset, no requests -> all m valids 0, all s readys 0, busy flags 0, grants 0.
- Slot 2 awvalid at cycle t, m awready held 1 -> m awvalid at t+1 carrying slot 2's awaddr=0x1000. Then a 4-beat W with wlast on beat 4, then B -> slot 2 bvalid with bresp=0. wr_busy_o drops the cycle after the B handshake.
- Slots 0..3 all issue single-beat reads continuously -> grant order 0,1,2,3,0. Each slot receives only its own rdata (tag=slot index); other slots' rvalid stays 0.
- Slot 1 long write (16 beats) concurrent with slot 3 read -> both busy flags high together. Both complete, and the write data is unaltered at the m port.
- Slot 0 asserts wvalid 3 cycles before awvalid -> wready stays 0 until the AW handshake; data arrives in order.
- reset_i asserted mid W_DATA (beat 2 of 8) -> m wvalid and m awvalid drop to 0 immediately. After release the FSM is idle and a new slot 3 write completes normally.

Source files
------------

// File: rtl/bsg_axi_bus_pkg.sv
// Shared AXI4 slot-mux types: write/read FSM state enums
// and width helpers for the flattened AXI4 bus bundles.
`ifndef BSG_SAFE_CLOG2
`define BSG_SAFE_CLOG2(x) (((x) <= 1) ? 1 : $clog2(x))
`endif

package bsg_axi_bus_pkg;

  typedef enum logic [1:0] {
    W_IDLE,
    W_ADDR,
    W_DATA,
    W_RESP
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_ADDR,
    R_DATA
  } rd_state_e;

  function automatic int safe_clog2(input int x);
    return `BSG_SAFE_CLOG2(x);
  endfunction

  // aw/ar: id+addr+30 each, w: data+strb+2, bready, rready
  function automatic int axi4_mosi_width(input int id_w,
                                         input int addr_w,
                                         input int data_w);
    return 2*id_w + 2*addr_w + data_w + data_w/8 + 64;
  endfunction

  // awready, wready, b(id+3), arready, r(id+data+4)
  function automatic int axi4_miso_width(input int id_w,
                                         input int data_w);
    return 2*id_w + data_w + 10;
  endfunction

endpackage

// File: rtl/axi4_slot_rr_arb.sv
// Round-robin picker for one AXI path: searches reqs_i upward
// from an internal pointer. Ports: clk_i, reset_i, reqs_i,
// yumi_i (pick taken), grant_one_hot_o, grant_o, v_o.
module axi4_slot_rr_arb
  import bsg_axi_bus_pkg::*;
#(
  parameter int slot_num_p = 4,
  localparam int gw_lp = safe_clog2(slot_num_p)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [slot_num_p-1:0] reqs_i,
  input  logic                  yumi_i,
  output logic [slot_num_p-1:0] grant_one_hot_o,
  output logic [gw_lp-1:0]      grant_o,
  output logic                  v_o
);

  logic [gw_lp-1:0] ptr_q, ptr_d;
  int idx;

  assign v_o = |reqs_i;

  // Walk downward so the closest request at or after ptr wins.
  always_comb begin
    idx = 0;
    grant_o = '0;
    for (int i = slot_num_p - 1; i >= 0; i--) begin
      idx = int'(ptr_q) + i;
      if (idx >= slot_num_p) idx = idx - slot_num_p;
      if (reqs_i[idx]) grant_o = gw_lp'(idx);
    end
  end

  assign grant_one_hot_o =
    v_o ? (slot_num_p'(1) << grant_o) : '0;

  // The pointer moves past the winner as soon as the grant is taken;
  // it is only consulted again in IDLE, after that burst has ended.
  always_comb begin
    ptr_d = ptr_q;
    if (yumi_i) begin
      if (grant_o == gw_lp'(slot_num_p - 1)) ptr_d = '0;
      else ptr_d = grant_o + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) ptr_q <= '0;
    else ptr_q <= ptr_d;
  end

endmodule

// File: rtl/axi4_slot_arbiter.sv
// Shares one AXI4 master port between slot_num_p slave slots, with
// independent single-burst round-robin write (AW/W/B) and read (AR/R)
// paths. Ports: s_axi4_par_i/o per-slot bundles, m_axi4_ser_o/i shared
// bundle, wr/rd_busy_o path activity, wr/rd_grant_o current/last owner.
module axi4_slot_arbiter
  import bsg_axi_bus_pkg::*;
#(
  parameter int slot_num_p = 4,
  parameter int id_width_p = 4,
  parameter int addr_width_p = 32,
  parameter int data_width_p = 32,
  localparam int gw_lp = safe_clog2(slot_num_p),
  localparam int mosi_w_lp =
    axi4_mosi_width(id_width_p, addr_width_p, data_width_p),
  localparam int miso_w_lp =
    axi4_miso_width(id_width_p, data_width_p)
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  input  logic [slot_num_p-1:0][mosi_w_lp-1:0] s_axi4_par_i,
  output logic [slot_num_p-1:0][miso_w_lp-1:0] s_axi4_par_o,
  output logic [mosi_w_lp-1:0]                 m_axi4_ser_o,
  input  logic [miso_w_lp-1:0]                 m_axi4_ser_i,
  output logic                                 wr_busy_o,
  output logic                                 rd_busy_o,
  output logic [gw_lp-1:0]                     wr_grant_o,
  output logic [gw_lp-1:0]                     rd_grant_o
);

  typedef struct packed {
    logic [id_width_p-1:0]   awid;
    logic [addr_width_p-1:0] awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awlock;
    logic [3:0]              awcache;
    logic [2:0]              awprot;
    logic [3:0]              awqos;
    logic [3:0]              awregion;
    logic                    awvalid;
  } aw_s;

  typedef struct packed {
    logic [data_width_p-1:0]   wdata;
    logic [data_width_p/8-1:0] wstrb;
    logic                      wlast;
    logic                      wvalid;
  } w_s;

  typedef struct packed {
    logic [id_width_p-1:0]   arid;
    logic [addr_width_p-1:0] araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arlock;
    logic [3:0]              arcache;
    logic [2:0]              arprot;
    logic [3:0]              arqos;
    logic [3:0]              arregion;
    logic                    arvalid;
  } ar_s;

  typedef struct packed {
    logic [id_width_p-1:0] bid;
    logic [1:0]            bresp;
    logic                  bvalid;
  } b_s;

  typedef struct packed {
    logic [id_width_p-1:0]   rid;
    logic [data_width_p-1:0] rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
  } r_s;

  typedef struct packed {
    aw_s  aw;
    w_s   w;
    logic bready;
    ar_s  ar;
    logic rready;
  } mosi_s;

  typedef struct packed {
    logic awready;
    logic wready;
    b_s   b;
    logic arready;
    r_s   r;
  } miso_s;

  mosi_s [slot_num_p-1:0] s_mosi;
  miso_s [slot_num_p-1:0] s_miso;
  mosi_s m_mosi;
  miso_s m_miso;

  assign s_mosi = s_axi4_par_i;
  assign s_axi4_par_o = s_miso;
  assign m_axi4_ser_o = m_mosi;
  assign m_miso = m_axi4_ser_i;

  wr_state_e wr_state_q, wr_state_d;
  rd_state_e rd_state_q, rd_state_d;
  logic [gw_lp-1:0] wr_grant_q, wr_grant_d;
  logic [gw_lp-1:0] rd_grant_q, rd_grant_d;

  logic [slot_num_p-1:0] w_reqs, r_reqs, w_oh, r_oh;
  logic [gw_lp-1:0] w_pick, r_pick;
  logic w_v, r_v;
  logic aw_hs, w_last_hs, b_hs, ar_hs, r_last_hs;

  for (genvar i = 0; i < slot_num_p; i++) begin : g_req
    assign w_reqs[i] = s_mosi[i].aw.awvalid;
    assign r_reqs[i] = s_mosi[i].ar.arvalid;
  end

  axi4_slot_rr_arb #(.slot_num_p(slot_num_p)) u_w_arb (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .reqs_i          (w_reqs),
    .yumi_i          (wr_state_q == W_IDLE && w_v),
    .grant_one_hot_o (w_oh),
    .grant_o         (w_pick),
    .v_o             (w_v)
  );

  axi4_slot_rr_arb #(.slot_num_p(slot_num_p)) u_r_arb (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .reqs_i          (r_reqs),
    .yumi_i          (rd_state_q == R_IDLE && r_v),
    .grant_one_hot_o (r_oh),
    .grant_o         (r_pick),
    .v_o             (r_v)
  );

  // Shared-port muxing; valids/readys only open in their own state.
  always_comb begin
    m_mosi = '0;
    s_miso = '0;
    m_mosi.aw = s_mosi[wr_grant_q].aw;
    m_mosi.aw.awvalid = (wr_state_q == W_ADDR)
                        & s_mosi[wr_grant_q].aw.awvalid;
    m_mosi.w = s_mosi[wr_grant_q].w;
    m_mosi.w.wvalid = (wr_state_q == W_DATA)
                      & s_mosi[wr_grant_q].w.wvalid;
    m_mosi.bready = (wr_state_q == W_RESP)
                    & s_mosi[wr_grant_q].bready;
    m_mosi.ar = s_mosi[rd_grant_q].ar;
    m_mosi.ar.arvalid = (rd_state_q == R_ADDR)
                        & s_mosi[rd_grant_q].ar.arvalid;
    m_mosi.rready = (rd_state_q == R_DATA)
                    & s_mosi[rd_grant_q].rready;
    s_miso[wr_grant_q].awready = (wr_state_q == W_ADDR)
                                 & m_miso.awready;
    s_miso[wr_grant_q].wready = (wr_state_q == W_DATA)
                                & m_miso.wready;
    if (wr_state_q == W_RESP) s_miso[wr_grant_q].b = m_miso.b;
    s_miso[rd_grant_q].arready = (rd_state_q == R_ADDR)
                                 & m_miso.arready;
    if (rd_state_q == R_DATA) s_miso[rd_grant_q].r = m_miso.r;
  end

  assign aw_hs = m_mosi.aw.awvalid & m_miso.awready;
  assign w_last_hs = m_mosi.w.wvalid & m_miso.wready & m_mosi.w.wlast;
  assign b_hs = m_mosi.bready & m_miso.b.bvalid;
  assign ar_hs = m_mosi.ar.arvalid & m_miso.arready;
  assign r_last_hs = m_mosi.rready & m_miso.r.rvalid & m_miso.r.rlast;

  always_comb begin
    wr_state_d = wr_state_q;
    wr_grant_d = wr_grant_q;
    unique case (wr_state_q)
      W_IDLE: if (w_v) begin
        wr_grant_d = w_pick;
        wr_state_d = W_ADDR;
      end
      W_ADDR: if (aw_hs) wr_state_d = W_DATA;
      W_DATA: if (w_last_hs) wr_state_d = W_RESP;
      W_RESP: if (b_hs) wr_state_d = W_IDLE;
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rd_grant_d = rd_grant_q;
    unique case (rd_state_q)
      R_IDLE: if (r_v) begin
        rd_grant_d = r_pick;
        rd_state_d = R_ADDR;
      end
      R_ADDR: if (ar_hs) rd_state_d = R_DATA;
      R_DATA: if (r_last_hs) rd_state_d = R_IDLE;
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_state_q <= W_IDLE;
      rd_state_q <= R_IDLE;
      wr_grant_q <= '0;
      rd_grant_q <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      wr_grant_q <= wr_grant_d;
      rd_grant_q <= rd_grant_d;
    end
  end

  assign wr_busy_o = (wr_state_q != W_IDLE);
  assign rd_busy_o = (rd_state_q != R_IDLE);
  assign wr_grant_o = wr_grant_q;
  assign rd_grant_o = rd_grant_q;

  always_ff @(posedge clk_i) begin
    assert (slot_num_p >= 2 && slot_num_p <= 16)
      else $error("slot_num_p out of range 2..16");
    assert ($onehot0(w_oh) && $onehot0(r_oh))
      else $error("arbiter grant not one-hot");
  end

endmodule
